// File: rtl/ascon_pkg.sv
// Ascon-128 shared definitions: IV, padding word,
// round constants, FSM encodings, phase start indices.
package ascon_pkg;

  localparam logic [63:0] ASCON_IV  = 64'h80400c0600000000;
  localparam logic [63:0] ASCON_PAD = 64'h8000000000000000;

  localparam logic [3:0] P12_START = 4'd0;
  localparam logic [3:0] P6_START  = 4'd6;
  localparam logic [3:0] LAST_RND  = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_AD1,
    S_AD2,
    S_CT,
    S_FIN,
    S_OUT
  } state_t;

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input int          n
  );
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon permutation round, purely combinational.
// s_in/s_out: 320-bit state {x0..x4}; rnd: round index 0..11.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] s_in,
  input  logic [3:0]   rnd,
  output logic [319:0] s_out
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;

  assign {x0, x1, x2, x3, x4} = s_in;

  // constant addition folded into the S-box input xors
  assign a0 = x0 ^ x4;
  assign a1 = x1;
  assign a2 = x2 ^ {56'd0, rc(rnd)} ^ x1;
  assign a3 = x3;
  assign a4 = x4 ^ x3;

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign c0 = b0 ^ b4;
  assign c1 = b1 ^ b0;
  assign c2 = ~b2;
  assign c3 = b3 ^ b2;
  assign c4 = b4;

  assign s_out = {
    c0 ^ ror(c0, 19) ^ ror(c0, 28),
    c1 ^ ror(c1, 61) ^ ror(c1, 39),
    c2 ^ ror(c2, 1)  ^ ror(c2, 6),
    c3 ^ ror(c3, 10) ^ ror(c3, 17),
    c4 ^ ror(c4, 7)  ^ ror(c4, 41)
  };

endmodule

// File: rtl/decrypt_1block_128.sv
// Iterative single-block Ascon-128 decrypt, one round/clock.
// In: CLK, RST, start, SK, N, A, C, T. Out: P, tag_ok, busy, done.
module decrypt_1block_128
  import ascon_pkg::*;
#(
  parameter logic [63:0] IV = ASCON_IV
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [63:0]  C,
  input  logic [127:0] T,
  output logic [63:0]  P,
  output logic         tag_ok,
  output logic         busy,
  output logic         done
);

  state_t state_q, state_d;

  logic [3:0]   cnt_q, cnt_d;
  logic [319:0] s_q, s_d, s_rnd;
  logic [127:0] sk_q, t_q;
  logic [63:0]  a_q, c_q;
  logic [63:0]  pt_q, pt_d;
  logic         hit_q, hit_d;
  logic [63:0]  r0, r1, r2, r3, r4;
  logic [63:0]  k_hi, k_lo;
  logic [63:0]  p_d;
  logic         ok_d, done_d;
  logic         accept, last;

  assign accept = (state_q == S_IDLE) && start;
  assign last   = (cnt_q == LAST_RND);
  assign k_hi   = sk_q[127:64];
  assign k_lo   = sk_q[63:0];

  assign {r0, r1, r2, r3, r4} = s_rnd;

  ascon_round u_round (
    .s_in  (s_q),
    .rnd   (cnt_q),
    .s_out (s_rnd)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: if (last)  state_d = S_AD1;
      S_AD1:  if (last)  state_d = S_AD2;
      S_AD2:  if (last)  state_d = S_CT;
      S_CT:   if (last)  state_d = S_FIN;
      S_FIN:  if (last)  state_d = S_OUT;
      S_OUT:             state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // round datapath; absorb steps ride on each phase's last round
  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    pt_d  = pt_q;
    hit_d = hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          s_d   = {IV, SK, N};
          cnt_d = P12_START;
          pt_d  = '0;
          hit_d = 1'b0;
        end
      end
      S_INIT: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          s_d   = {r0 ^ a_q, r1, r2, r3 ^ k_hi, r4 ^ k_lo};
          cnt_d = P6_START;
        end
      end
      S_AD1: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          s_d   = {r0 ^ ASCON_PAD, r1, r2, r3, r4};
          cnt_d = P6_START;
        end
      end
      S_AD2: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          s_d   = {c_q, r1, r2, r3, r4 ^ 64'd1};
          pt_d  = r0 ^ c_q;
          cnt_d = P6_START;
        end
      end
      S_CT: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          s_d   = {r0 ^ ASCON_PAD, r1 ^ k_hi, r2 ^ k_lo, r3, r4};
          cnt_d = P12_START;
        end
      end
      S_FIN: begin
        s_d   = s_rnd;
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          hit_d = ({r3 ^ k_hi, r4 ^ k_lo} == t_q);
          cnt_d = P12_START;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE) || done;
    done_d = (state_q == S_OUT);
    p_d    = P;
    ok_d   = tag_ok;
    if (accept) begin
      p_d  = '0;
      ok_d = 1'b0;
    end else if (state_q == S_OUT) begin
      p_d  = hit_q ? pt_q : '0;
      ok_d = hit_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      s_q   <= '0;
      pt_q  <= '0;
      hit_q <= 1'b0;
      sk_q  <= '0;
      t_q   <= '0;
      a_q   <= '0;
      c_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      s_q   <= s_d;
      pt_q  <= pt_d;
      hit_q <= hit_d;
      if (accept) begin
        sk_q <= SK;
        t_q  <= T;
        a_q  <= A;
        c_q  <= C;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      P      <= '0;
      tag_ok <= 1'b0;
      done   <= 1'b0;
    end else begin
      P      <= p_d;
      tag_ok <= ok_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_decrypt_1block_128.sv
// Bench for decrypt_1block_128: Ascon sponge model plus
// cycle-level protocol model, directed vectors.
module tb_decrypt_1block_128;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [127:0] SK = '0;
  logic [127:0] N = '0;
  logic [63:0]  A = '0;
  logic [63:0]  C = '0;
  logic [127:0] T = '0;
  logic [63:0]  P;
  logic         tag_ok, busy, done;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  decrypt_1block_128 dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .SK     (SK),
    .N      (N),
    .A      (A),
    .C      (C),
    .T      (T),
    .P      (P),
    .tag_ok (tag_ok),
    .busy   (busy),
    .done   (done)
  );

  localparam logic [63:0] IV_M  = 64'h80400c0600000000;
  localparam logic [63:0] PAD_M = 64'h8000000000000000;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int R1 [5] = '{19, 61, 1, 10, 7};
  localparam int R2 [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rot(logic [63:0] v, int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] rnd_m(logic [319:0] s, int i);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    for (int k = 0; k < 5; k++) x[k] = s[319-64*k -: 64];
    x[2] ^= 64'((15 - i) * 16 + i);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SBOX[col];
      for (int k = 0; k < 5; k++) y[k][b] = o[4-k];
    end
    for (int k = 0; k < 5; k++)
      x[k] = y[k] ^ rot(y[k], R1[k]) ^ rot(y[k], R2[k]);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] perm(logic [319:0] s, int nr);
    logic [319:0] t;
    t = s;
    for (int i = 12 - nr; i < 12; i++) t = rnd_m(t, i);
    return t;
  endfunction

  // returns {out block, tag}; dec selects decrypt absorb
  function automatic logic [191:0] sponge(
    input logic [127:0] k,
    input logic [127:0] n,
    input logic [63:0]  a,
    input logic [63:0]  din,
    input logic         dec
  );
    logic [319:0] s;
    logic [63:0]  o;
    s = perm({IV_M, k, n}, 12);
    s[127:0] ^= k;
    s[319:256] ^= a;
    s = perm(s, 6);
    s[319:256] ^= PAD_M;
    s = perm(s, 6);
    s[0] ^= 1'b1;
    o = s[319:256] ^ din;
    s[319:256] = dec ? din : o;
    s = perm(s, 6);
    s[319:256] ^= PAD_M;
    s[255:128] ^= k;
    s = perm(s, 12);
    return {o, s[127:0] ^ k};
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // protocol model: done 43 edges after acceptance
  logic         m_act = 1'b0;
  logic         m_done = 1'b0;
  logic         m_ok = 1'b0;
  logic [63:0]  m_P = '0;
  int           m_left = 0;
  logic [191:0] m_r = '0;
  logic [127:0] m_T = '0;
  logic [63:0]  e_P;
  logic         e_ok;

  assign e_P  = m_r[191:128];
  assign e_ok = (m_r[127:0] == m_T);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_ok   <= 1'b0;
      m_P    <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_act) begin
        if (m_left == 1) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
          m_ok   <= e_ok;
          m_P    <= e_ok ? e_P : '0;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_r    <= sponge(SK, N, A, C, 1'b1);
        m_T    <= T;
        m_act  <= 1'b1;
        m_left <= 43;
        m_P    <= '0;
        m_ok   <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("busy", 128'(busy), 128'(m_act || m_done));
      chk("done", 128'(done), 128'(m_done));
      chk("P", 128'(P), 128'(m_P));
      chk("tag_ok", 128'(tag_ok), 128'(m_ok));
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic put(input logic [127:0] k,
                     input logic [127:0] n,
                     input logic [63:0]  a,
                     input logic [63:0]  c,
                     input logic [127:0] t);
    SK = k;
    N  = n;
    A  = a;
    C  = c;
    T  = t;
  endtask

  task automatic run(input logic [127:0] k,
                     input logic [127:0] n,
                     input logic [63:0]  a,
                     input logic [63:0]  c,
                     input logic [127:0] t,
                     output int lat);
    put(k, n, a, c, t);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat);
  endtask

  localparam logic [127:0] K0 =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [63:0]  P0 = 64'h0001020304050607;
  localparam logic [127:0] K1 =
    128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] N1 =
    128'ha5a5a5a55a5a5a5a0123456789abcdef;
  localparam logic [63:0]  A1 = 64'hdeadbeefcafef00d;
  localparam logic [63:0]  P1 = 64'h1122334455667788;

  logic [191:0] r0, r1, d0;
  logic [319:0] pin;
  logic [63:0]  C0, C1;
  logic [127:0] T0, T1;
  int           lat, gap;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    pin = rnd_m(320'd0, 0);
    chk("pin_x0", 128'(pin[319:256]), 128'h001e0f00000000f0);
    chk("pin_x1", 128'(pin[255:192]), 128'h00000001e0000770);
    chk("pin_x3", 128'(pin[127:64]), 128'h3c780000000000f0);

    r0 = sponge(K0, K0, P0, P0, 1'b0);
    C0 = r0[191:128];
    T0 = r0[127:0];
    r1 = sponge(K1, N1, A1, P1, 1'b0);
    C1 = r1[191:128];
    T1 = r1[127:0];
    d0 = sponge(K0, K0, P0, C0, 1'b1);
    chk("model_pt", 128'(d0[191:128]), 128'(P0));
    chk("model_tag", d0[127:0], T0);

    repeat (3) step();
    chk("rst_P", 128'(P), 128'd0);
    chk("rst_ok", 128'(tag_ok), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    RST = 1'b0;
    step();

    run(K0, K0, P0, C0, T0, lat);
    chk("rt_lat", 128'(lat), 128'd43);
    chk("rt_P", 128'(P), 128'(P0));
    chk("rt_ok", 128'(tag_ok), 128'd1);
    repeat (3) step();
    chk("rt_hold", 128'(P), 128'(P0));

    run(K0, K0, P0, C0, T0 ^ 128'd1, lat);
    chk("tt_lat", 128'(lat), 128'd43);
    chk("tt_P", 128'(P), 128'd0);
    chk("tt_ok", 128'(tag_ok), 128'd0);
    step();

    run(K0, K0, P0, C0 ^ PAD_M, T0, lat);
    chk("ct_lat", 128'(lat), 128'd43);
    chk("ct_P", 128'(P), 128'd0);
    chk("ct_ok", 128'(tag_ok), 128'd0);
    step();

    put(K0, K0, P0, C0, T0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    RST = 1'b1;
    #1;
    chk("mr_busy", 128'(busy), 128'd0);
    chk("mr_done", 128'(done), 128'd0);
    chk("mr_P", 128'(P), 128'd0);
    chk("mr_ok", 128'(tag_ok), 128'd0);
    step();
    step();
    RST = 1'b0;
    step();
    chk("mr_nodone", 128'(done), 128'd0);
    run(K1, N1, A1, C1, T1, lat);
    chk("mr_lat", 128'(lat), 128'd43);
    chk("mr_newP", 128'(P), 128'(P1));
    chk("mr_newok", 128'(tag_ok), 128'd1);
    step();

    put(K0, K0, P0, C0, T0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    put(K1, N1, A1, C1, T1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat);
    chk("bs_lat", 128'(lat + 10), 128'd43);
    chk("bs_P", 128'(P), 128'(P0));
    chk("bs_ok", 128'(tag_ok), 128'd1);
    step();

    put(K0, K0, P0, C0, T0);
    start = 1'b1;
    step();
    wait_done(lat);
    chk("bb_lat", 128'(lat), 128'd43);
    chk("bb_P0", 128'(P), 128'(P0));
    put(K1, N1, A1, C1, T1);
    step();
    gap = 1;
    while (done !== 1'b1 && gap < 200) begin
      step();
      gap++;
    end
    start = 1'b0;
    chk("bb_gap", 128'(gap), 128'd44);
    chk("bb_P1", 128'(P), 128'(P1));
    chk("bb_ok", 128'(tag_ok), 128'd1);

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decrypt_1block_128.md
# decrypt_1block_128

Iterative Ascon-128 authenticated decryption core: takes a 128-bit key, a 128-bit nonce, one 64-bit associated-data block, one 64-bit ciphertext block and a 128-bit tag. It recovers the 64-bit plaintext and verifies the tag. It is the receive-side counterpart of the single-block Ascon-128 encrypt core, and any (C, T) pair produced by that core must decrypt here with `tag_ok=1`. One permutation round is computed per clock. Plaintext is released only when the tag verifies.

## Interface
Parameters:
- `IV`, default `64'h80400c0600000000`: Ascon-128 initialisation word (k=128, r=64, a=12, b=6).

Ports:
- `CLK`, in, 1: clock; all state updates on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request; sampled only while in IDLE.
- `SK`, in, 128: secret key; sampled on the accepted `start`.
- `N`, in, 128: nonce; sampled on the accepted `start`.
- `A`, in, 64: associated-data block, always a full block; sampled on the accepted `start`.
- `C`, in, 64: ciphertext block, always a full block; sampled on the accepted `start`.
- `T`, in, 128: received tag; sampled on the accepted `start`.
- `P`, out, 64: plaintext if the tag matched, otherwise all zeros.
- `tag_ok`, out, 1: 1 when the computed tag equals `T`.
- `busy`, out, 1: high from the accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse when `P` and `tag_ok` are valid.

## Operation
- State is 320 bits, x0..x4 with x0 as the MSW. Operand registers hold `SK`, `C` and `T` for the whole operation.
- FSM states: IDLE, INIT (12 rounds), AD1 (6), AD2 (6), CT (6), FIN (12), OUT.
- A 4-bit round counter runs from the phase's first round index to 11.
  - p12 uses indices 0..11; p6 uses indices 6..11.
  - Round constant for index i is `{4'hF-i, i}`, XORed into the low byte of x2.
- IDLE + `start`: load state = `{IV, SK, N}`, latch the operands, go to INIT.
- At the last INIT round edge: x3 ^= SK[127:64], x4 ^= SK[63:0], x0 ^= A; go to AD1.
- At the last AD1 edge: x0 ^= `64'h8000000000000000` (AD padding block); go to AD2.
- At the last AD2 edge:
  - x4 ^= 1 (domain separation).
  - Plaintext register = x0 ^ C.
  - x0 = C.
  - Go to CT.
- At the last CT edge: x0 ^= `64'h8000…0` (empty final padded block); x1 ^= SK[127:64]; x2 ^= SK[63:0]; go to FIN.
- At the last FIN edge: computed tag = {x3 ^ SK[127:64], x4 ^ SK[63:0]}; compare with `T`; go to OUT.
- OUT, for one cycle:
  - Drive `done`=1.
  - Register `P` as the plaintext register if the tags match, else 0.
  - Register `tag_ok`.
  - Return to IDLE.
- `start` while not in IDLE is ignored; no queuing.
- `RST` mid-operation: return to IDLE immediately, discard all state, no `done`.

## Timing
- Reset values: `P`=0, `tag_ok`=0, `busy`=0, `done`=0, FSM=IDLE, state and operand registers zero.
- `start` accepted at edge 0.
- Rounds execute on edges 1..42 (12+6+6+6+12).
- OUT is entered at edge 42.
- `done`, `P` and `tag_ok` are valid in the cycle after edge 43 is… specifically: `done` is high for exactly one cycle, 43 cycles after acceptance.
- `P` and `tag_ok` hold their values until the next accepted `start`, then clear to 0 at that edge.
- `busy` rises at edge 0 and falls with the end of `done`.
- The earliest next `start` is the cycle `done` is high; it is accepted at the following edge, giving back-to-back throughput of 44 cycles per block.
- Tag compare is a full 128-bit equality. No early exit on mismatch: latency is identical for pass and fail.

## Structure
- Shared package/include `ascon_pkg`:
  - IV constant.
  - Padding word `64'h8000000000000000`.
  - Round-constant function.
  - FSM state encodings.
  - Phase round-start indices (0, 6).
- Sub-module `ascon_round`, purely combinational, 320 bits in plus a 4-bit index, 320 bits out:
  - Constant addition.
  - 5-bit S-box.
  - Linear layer with rotations (19,28), (61,39), (1,6), (10,17), (7,41).
  - Shared with the encrypt core.
- Top-level FSM, counter, absorb muxes and output registers live in this module.

## Test plan
- Round trip: SK=N=`000102…0F`, A=P=`0001020304050607` through the encrypt core, then decrypt its (C, T) -> `P`=`0001020304050607`, `tag_ok`=1, `done` exactly 43 cycles after acceptance.
- Tag tamper: same inputs with T[0] flipped -> `tag_ok`=0, `P`=0, same 43-cycle latency.
- Ciphertext tamper: C[63] flipped with the original T -> `tag_ok`=0, `P`=0.
- Reset mid-run: assert `RST` at cycle 20 -> `busy`/`done`/`P`/`tag_ok` go to 0 immediately, no `done`; a new `start` then completes correctly in 43 cycles.
- Busy start: pulse `start` with different operands at cycle 10 -> ignored; the result matches the first request; `busy` stays high with no glitch.
- Back-to-back: `start` held high continuously over two vector sets -> two `done` pulses 44 cycles apart, each with the correct `P`.
